// File: rtl/guess_pkg.sv
// Shared types and encodings for the number-guessing round controller.
package guess_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        PLAY  = 3'd1,
        CHECK = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] HINT_NONE   = 2'b00;
    localparam logic [1:0] HINT_HIGHER = 2'b01;
    localparam logic [1:0] HINT_LOWER  = 2'b10;
    localparam logic [1:0] HINT_EQUAL  = 2'b11;

    localparam logic [1:0] ST_BUSY = 2'b00;
    localparam logic [1:0] ST_WIN  = 2'b01;
    localparam logic [1:0] ST_LOSE = 2'b10;

endpackage

// File: rtl/bcd_digit_cell.sv
// One guess digit: button edge detector feeding a mod-10 counter.
// The button is registered once before the edge compare, so a press lands two clocks later.
module bcd_digit_cell
    import guess_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic btn,
    input  logic en,
    output bcd_t digit
);

    logic btn_q;
    logic btn_prev;
    logic rise;

    assign rise = btn_q & ~btn_prev;

    always_ff @(posedge clk) begin
        if (clr) begin
            btn_q    <= 1'b0;
            btn_prev <= 1'b0;
            digit    <= 4'd0;
        end else begin
            btn_q    <= btn;
            btn_prev <= btn_q;
            if (en && rise) begin
                digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/guess_round_ctrl.sv
// Game controller: fetches targets, edits the BCD guess, compares on confirm
// and tracks round/level/attempts through to WIN or LOSE.
module guess_round_ctrl
    import guess_pkg::*;
#(
    parameter int NUM_DIGITS       = 3,
    parameter int NUM_LEVELS       = 3,
    parameter int ROUNDS_PER_LEVEL = 3,
    parameter int BASE_ATTEMPTS    = 3,
    localparam int DW = 4 * NUM_DIGITS,
    localparam int LW = $clog2(NUM_LEVELS + 1),
    localparam int RW = $clog2(ROUNDS_PER_LEVEL + 1),
    localparam int AW = $clog2(BASE_ATTEMPTS + NUM_LEVELS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIGITS-1:0] digit_btn,
    input  logic                  confirm_btn,
    output logic                  tgt_req,
    input  logic                  tgt_valid,
    input  logic [DW-1:0]         tgt_bcd,
    output logic [DW-1:0]         guess_bcd,
    output logic [1:0]            hint,
    output logic                  hint_valid,
    output logic [LW-1:0]         level,
    output logic [RW-1:0]         round,
    output logic [AW-1:0]         attempts_left,
    output logic [1:0]            status,
    output state_t                state
);

    // Handshake: a target is taken on any clock where tgt_req && tgt_valid;
    // tgt_req stays high from entry into FETCH until that clock, never withdrawn early.

    state_t          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [RW-1:0]   round_q, round_d;
    logic [AW-1:0]   att_q, att_d;
    logic [1:0]      hint_q, hint_d;
    logic            hv_q, hv_d;
    logic            req_q, req_d;
    logic [DW-1:0]   tgt_q, tgt_d;
    logic [DW-1:0]   act_mask;
    logic [DW-1:0]   guess_m;
    logic            conf_q, conf_prev, conf_rise;
    logic            play_edit;
    logic [NUM_DIGITS-1:0] dig_en;

    assign conf_rise = conf_q & ~conf_prev;

    // Confirm wins over digit edges arriving in the same cycle.
    assign play_edit = (state_q == PLAY) && !conf_rise;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign dig_en[g] = play_edit && (g <= int'(level_q));
        bcd_digit_cell u_cell (
            .clk   (clk),
            .clr   (rst),
            .btn   (digit_btn[g]),
            .en    (dig_en[g]),
            .digit (guess_bcd[4*g +: 4])
        );
    end

    always_comb begin
        act_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            act_mask[4*i +: 4] = (i <= int'(level_q)) ? 4'hF : 4'h0;
        end
    end

    assign guess_m = guess_bcd & act_mask;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        round_d = round_q;
        att_d   = att_q;
        hint_d  = hint_q;
        hv_d    = 1'b0;
        tgt_d   = tgt_q;
        case (state_q)
            FETCH: begin
                if (req_q && tgt_valid) begin
                    tgt_d   = tgt_bcd & act_mask;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (conf_rise) state_d = CHECK;
            end
            CHECK: begin
                hv_d = 1'b1;
                // Packed BCD orders the same as its decimal value.
                if (guess_m == tgt_q) begin
                    hint_d = HINT_EQUAL;
                    if (int'(round_q) + 1 < ROUNDS_PER_LEVEL) begin
                        round_d = round_q + RW'(1);
                        state_d = FETCH;
                    end else if (int'(level_q) < NUM_LEVELS - 1) begin
                        level_d = level_q + LW'(1);
                        round_d = '0;
                        att_d   = AW'(BASE_ATTEMPTS) + AW'(level_q) + AW'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = WIN;
                    end
                end else begin
                    hint_d = (tgt_q > guess_m) ? HINT_HIGHER : HINT_LOWER;
                    if (att_q > AW'(1)) begin
                        att_d   = att_q - AW'(1);
                        state_d = PLAY;
                    end else begin
                        att_d   = '0;
                        state_d = LOSE;
                    end
                end
            end
            default: ;
        endcase
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            level_q   <= '0;
            round_q   <= '0;
            att_q     <= AW'(BASE_ATTEMPTS);
            hint_q    <= HINT_NONE;
            hv_q      <= 1'b0;
            req_q     <= 1'b0;
            tgt_q     <= '0;
            conf_q    <= 1'b0;
            conf_prev <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            round_q   <= round_d;
            att_q     <= att_d;
            hint_q    <= hint_d;
            hv_q      <= hv_d;
            req_q     <= req_d;
            tgt_q     <= tgt_d;
            conf_q    <= confirm_btn;
            conf_prev <= conf_q;
        end
    end

    assign tgt_req       = req_q;
    assign hint          = hint_q;
    assign hint_valid    = hv_q;
    assign level         = level_q;
    assign round         = round_q;
    assign attempts_left = att_q;
    assign state         = state_q;
    assign status        = (state_q == WIN)  ? ST_WIN  :
                           (state_q == LOSE) ? ST_LOSE : ST_BUSY;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl at default parameters.
module tb_guess_round_ctrl;
    import guess_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  digit_btn = '0;
    logic        confirm_btn = 1'b0;
    logic        tgt_req;
    logic        tgt_valid = 1'b0;
    logic [11:0] tgt_bcd = '0;
    logic [11:0] guess_bcd;
    logic [1:0]  hint_obs;
    logic        hv_obs;
    logic [1:0]  level;
    logic [1:0]  round;
    logic [2:0]  attempts_left;
    logic [1:0]  status;
    state_t      state;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_dig[3];

    always #5 clk = ~clk;

    guess_round_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .digit_btn     (digit_btn),
        .confirm_btn   (confirm_btn),
        .tgt_req       (tgt_req),
        .tgt_valid     (tgt_valid),
        .tgt_bcd       (tgt_bcd),
        .guess_bcd     (guess_bcd),
        .hint          (hint_obs),
        .hint_valid    (hv_obs),
        .level         (level),
        .round         (round),
        .attempts_left (attempts_left),
        .status        (status),
        .state         (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_guess();
        return {4'(exp_dig[2]), 4'(exp_dig[1]), 4'(exp_dig[0])};
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        digit_btn = '0;
        confirm_btn = 1'b0;
        tgt_valid = 1'b0;
        for (int i = 0; i < 3; i++) exp_dig[i] = 0;
        repeat (cycles) @(negedge clk);
        check("rst_state", 32'(state), 32'(FETCH));
        check("rst_guess", guess_bcd, 0);
        check("rst_hint", hint_obs, 0);
        check("rst_hv", hv_obs, 0);
        check("rst_level", level, 0);
        check("rst_round", round, 0);
        check("rst_att", attempts_left, 3);
        check("rst_status", status, 0);
        check("rst_req", tgt_req, 0);
        rst = 1'b0;
        @(negedge clk);
        check("req_rise", tgt_req, 1);
    endtask

    task automatic supply(input logic [11:0] t);
        for (int i = 0; i < 20 && tgt_req !== 1'b1; i++) @(negedge clk);
        check("req_wait", tgt_req, 1);
        tgt_valid = 1'b1;
        tgt_bcd = t;
        @(negedge clk);
        tgt_valid = 1'b0;
        tgt_bcd = '0;
        check("req_drop", tgt_req, 0);
    endtask

    task automatic press_n(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            digit_btn[d] = 1'b1;
            @(negedge clk);
            digit_btn[d] = 1'b0;
            @(negedge clk);
            exp_dig[d] = (exp_dig[d] + 1) % 10;
        end
    endtask

    task automatic goto_guess(input logic [11:0] t);
        logic [11:0] tv;
        tv = t;
        for (int d = 0; d < 3; d++) begin
            press_n(d, (int'(tv[4*d +: 4]) - exp_dig[d] + 10) % 10);
        end
        check("guess_set", guess_bcd, exp_guess());
    endtask

    task automatic confirm_wait();
        int lat;
        lat = 0;
        confirm_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                confirm_btn = 1'b0;
                digit_btn = '0;
            end
            if (hv_obs === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("hv_latency", lat, 3);
    endtask

    logic [11:0] tgts[6]  = '{12'h057, 12'h096, 12'h021, 12'h123, 12'h555, 12'h999};
    logic [1:0]  exp_lv[6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [1:0]  exp_rd[6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2};
    logic [1:0]  exp_st[6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

    initial begin
        // Full winning game.
        do_reset(3);
        supply(12'h002);
        press_n(0, 2);
        check("g002", guess_bcd, 12'h002);
        confirm_wait();
        check("h_eq1", hint_obs, 2'b11);
        check("rd1", round, 1);
        supply(12'h008);
        press_n(0, 6);
        check("g008", guess_bcd, 12'h008);
        confirm_wait();
        check("rd2", round, 2);
        supply(12'h003);
        press_n(0, 5);
        check("g003_wrap", guess_bcd, 12'h003);
        confirm_wait();
        check("lv1", level, 1);
        check("lv1_rd", round, 0);
        check("lv1_att", attempts_left, 4);
        for (int j = 0; j < 6; j++) begin
            supply(tgts[j]);
            goto_guess(tgts[j]);
            confirm_wait();
            check("win_hint", hint_obs, 2'b11);
            check("win_lv", level, exp_lv[j]);
            check("win_rd", round, exp_rd[j]);
            check("win_st", status, exp_st[j]);
        end
        check("lv2_att", attempts_left, 5);
        digit_btn = 3'b111;
        confirm_btn = 1'b1;
        repeat (2) @(negedge clk);
        digit_btn = '0;
        confirm_btn = 1'b0;
        repeat (5) @(negedge clk);
        check("win_guess_hold", guess_bcd, 12'h999);
        check("win_status_hold", status, 2'b01);
        check("win_no_req", tgt_req, 0);
        check("win_no_hv", hv_obs, 0);

        // Three wrong guesses at level 0.
        do_reset(2);
        check("rst_hint_clear", hint_obs, 0);
        supply(12'h008);
        press_n(0, 9);
        check("g009", guess_bcd, 12'h009);
        for (int j = 0; j < 3; j++) begin
            confirm_wait();
            check("lose_hint", hint_obs, 2'b10);
            check("lose_att", attempts_left, 3'(2 - j));
            check("lose_st", status, (j == 2) ? 2'b10 : 2'b00);
        end
        check("lose_state", 32'(state), 32'(LOSE));

        // Inactive digit, then digit+confirm in the same cycle.
        do_reset(2);
        supply(12'h005);
        digit_btn[2] = 1'b1;
        repeat (2) @(negedge clk);
        digit_btn[2] = 1'b0;
        repeat (2) @(negedge clk);
        check("inactive_digit", guess_bcd, 12'h000);
        digit_btn[0] = 1'b1;
        confirm_wait();
        check("same_cyc_hint", hint_obs, 2'b01);
        check("same_cyc_att", attempts_left, 2);
        repeat (2) @(negedge clk);
        check("same_cyc_guess", guess_bcd, 12'h000);
        press_n(0, 5);
        confirm_wait();
        check("c_rd1", round, 1);

        // Reset while a request is outstanding.
        repeat (2) @(negedge clk);
        check("mid_req", tgt_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_req_drop", tgt_req, 0);
        check("mid_rd", round, 0);
        check("mid_att", attempts_left, 3);
        check("mid_lv", level, 0);
        check("mid_guess", guess_bcd, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_req_again", tgt_req, 1);
        supply(12'h001);
        check("mid_state_play", 32'(state), 32'(PLAY));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Parametrised game-control core for the number-guessing design; successor to the fixed 3-digit, 3-difficulty controller.
- Holds the BCD guess, fetches targets through a handshake, and compares guesses on confirm.
- Tracks round, level and remaining attempts, and produces higher/lower/equal hints plus a terminal WIN or LOSE status.
- Sits between the debounced pushbuttons and the 7-segment/LED display logic.

Parameters:
- NUM_DIGITS, 3, number of BCD guess digits (1..8).
- NUM_LEVELS, 3, number of difficulty levels; level L (0-based) uses min(L+1, NUM_DIGITS) low digits.
- ROUNDS_PER_LEVEL, 3, correct guesses required to clear a level.
- BASE_ATTEMPTS, 3, wrong-guess budget at level 0; level L budget = BASE_ATTEMPTS+L, reloaded at each level start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digit_btn  in  NUM_DIGITS  debounced level inputs; bit i increments digit i.
- confirm_btn  in  1  debounced level input; submits the guess.
- tgt_req  out  1  request for a new target.
- tgt_valid  in  1  target-source response; accepted when tgt_req && tgt_valid.
- tgt_bcd  in  4*NUM_DIGITS  target digits, valid with tgt_valid.
- guess_bcd  out  4*NUM_DIGITS  current guess.
- hint  out  2  01=higher, 10=lower, 11=equal, 00=none.
- hint_valid  out  1  one-cycle pulse when hint updates.
- level  out  $clog2(NUM_LEVELS+1)  current level (0-based).
- round  out  $clog2(ROUNDS_PER_LEVEL+1)  rounds won in current level.
- attempts_left  out  $clog2(BASE_ATTEMPTS+NUM_LEVELS+1)  remaining wrong guesses.
- status  out  2  00=busy/playing, 01=WIN, 10=LOSE.

Behaviour:
- Reset values (cycle after rst high): state FETCH, guess_bcd=0, hint=00, hint_valid=0, level=0, round=0, attempts_left=BASE_ATTEMPTS, status=00, tgt_req=0.
  - tgt_req rises the first cycle after rst falls.
  - rst mid-operation, including mid-handshake, overrides everything; a pending request is dropped.
- Edge detection: registered previous value of every button; action occurs on rising edge only; holding a button has no further effect.
- States: FETCH -> PLAY -> CHECK -> {PLAY, FETCH, WIN, LOSE}.
- FETCH:
  - tgt_req=1 until handshake.
  - On handshake, latch tgt_bcd with digits >= active count forced to 0; next state PLAY.
  - Button edges are ignored in FETCH.
- PLAY:
  - digit i rising edge: digit i <= (digit i == 9) ? 0 : digit i + 1, for i < active digit count; edges on inactive digits are ignored.
  - Several digit edges in one cycle all apply.
  - Guess is not cleared between rounds or levels.
  - Confirm edge -> CHECK. Confirm has priority: digit edges in the same cycle are dropped.
- CHECK (exactly one cycle): compare active digits numerically, set hint, and pulse hint_valid the next cycle.
  - Equal, round+1 < ROUNDS_PER_LEVEL: round++, go to FETCH.
  - Equal, round+1 == ROUNDS_PER_LEVEL, level < NUM_LEVELS-1: level++, round=0, reload attempts, go to FETCH.
  - Equal, last round of last level: WIN.
  - Not equal, attempts_left > 1: attempts_left--, go to PLAY.
  - Not equal, attempts_left == 1: attempts_left=0, go to LOSE.
- WIN/LOSE: terminal until rst. Status held, all buttons ignored, tgt_req=0.
- Latency:
  - Confirm rising edge to hint_valid = 3 clocks: edge register, CHECK, output register.
  - Digit rising edge to guess_bcd update = 2 clocks.

Decomposition:
- Package guess_pkg holds:
  - state_t enum (FETCH, PLAY, CHECK, WIN, LOSE);
  - hint_t localparams HINT_NONE/HIGHER/LOWER/EQUAL;
  - status localparams ST_BUSY/ST_WIN/ST_LOSE;
  - typedef bcd_t logic[3:0].
- One sub-module, bcd_digit_cell: per-digit edge detector plus mod-10 counter with enable and sync clear; instantiated NUM_DIGITS times via generate.

Test Plan (defaults; target source returns 002,008,003 / 057,096,021 / 123,555,999 in order):
- rst high 3 cycles, then low -> all reset values, tgt_req=1 from first post-reset cycle, target 002 accepted.
- 2×digit0, confirm -> hint=11, round=1; 6 more digit0 (guess 008), confirm -> round=2; 5 more (wraps to 003), confirm -> level=1, round=0, attempts_left=4.
- Full win sequence across all 9 targets -> status=01 after the 999 confirm. Later presses leave guess_bcd=999 and status=01.
- Level 0, target 008, guess 009 confirmed 3 times -> hint=10 each time, attempts 2,1,0; status=10 after the third.
- Level 0: digit2 pressed (inactive digit) -> guess unchanged. digit0 and confirm edges in the same cycle -> compares the old guess, and the digit press is lost.
- rst asserted while tgt_req=1 with tgt_valid low -> tgt_req drops, level/round/attempts back to reset values; a new fetch starts after rst falls.
